// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the RAM bus arbiter: FSM states, grant owner, timer width.
package mem_bus_arbiter_pkg;

   localparam int CNT_WIDTH = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CPU_ACC  = 3'd1,
      ST_CPU_DONE = 3'd2,
      ST_DEV_ACC  = 3'd3,
      ST_DEV_DONE = 3'd4
   } arb_state_t;

   typedef enum logic {
      GRANT_CPU = 1'b0,
      GRANT_DEV = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_bus_arbiter_access_timer.sv
// Loadable down-counter that times one RAM strobe; o_zero marks the last strobe cycle.
module access_timer
   import mem_bus_arbiter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic             clk_in,
   input  logic             n_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk_in) begin
      if (!n_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one RAM bus between the CPU (stalled via cpu_n_rdy) and a req/ack device,
// generating timed mem_n_oe / mem_n_we strobes with round-robin arbitration on ties.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | bus free, no strobes; grant decision on every edge
// ST_CPU_ACC  | CPU access, strobe low for ACCESS_CYCLES cycles
// ST_CPU_DONE | strobes high, write address/data held, CPU released
// ST_DEV_ACC  | device access, strobe low for ACCESS_CYCLES cycles
// ST_DEV_DONE | strobes high, write address/data held, dev_ack pulses
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ACCESS_CYCLES = 2,
   parameter int ADDR_WIDTH    = 16,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                  clk_in,
   input  logic                  n_rst,
   input  logic [ADDR_WIDTH-1:0] cpu_a,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic                  cpu_n_oe,
   input  logic                  cpu_n_we,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_n_rdy,
   input  logic                  dev_req,
   input  logic                  dev_we,
   input  logic [ADDR_WIDTH-1:0] dev_a,
   input  logic [DATA_WIDTH-1:0] dev_wdata,
   output logic                  dev_ack,
   output logic [DATA_WIDTH-1:0] dev_rdata,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_d_oe,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_n_oe,
   output logic                  mem_n_we
);

   localparam logic [CNT_WIDTH-1:0] LP_LOAD = CNT_WIDTH'(ACCESS_CYCLES - 1);

   arb_state_t            r_state;
   arb_state_t            w_next;
   grant_t                r_last_grant;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_cpu_rdata;
   logic [DATA_WIDTH-1:0] r_dev_rdata;

   logic w_cpu_req;
   logic w_grant_cpu;
   logic w_grant_dev;
   logic w_zero;
   logic w_acc;
   logic w_done;

   assign w_cpu_req = ~cpu_n_oe | ~cpu_n_we;

   access_timer #(.WIDTH(CNT_WIDTH)) u_timer (
      .clk_in     (clk_in),
      .n_rst      (n_rst),
      .i_load     (w_grant_cpu | w_grant_dev),
      .i_load_val (LP_LOAD),
      .i_en       (w_acc),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk_in) begin
      if (!n_rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= GRANT_DEV;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_we         <= 1'b0;
         r_cpu_rdata  <= '0;
         r_dev_rdata  <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant_cpu) begin
            r_addr       <= cpu_a;
            r_wdata      <= cpu_wdata;
            r_we         <= ~cpu_n_we;
            r_last_grant <= GRANT_CPU;
         end else if (w_grant_dev) begin
            r_addr       <= dev_a;
            r_wdata      <= dev_wdata;
            r_we         <= dev_we;
            r_last_grant <= GRANT_DEV;
         end
         // Read data is taken on the edge that ends the strobe.
         if ((r_state == ST_CPU_ACC) && w_zero && !r_we) begin
            r_cpu_rdata <= mem_rdata;
         end
         if ((r_state == ST_DEV_ACC) && w_zero && !r_we) begin
            r_dev_rdata <= mem_rdata;
         end
      end
   end

   always_comb begin
      w_next      = r_state;
      w_grant_cpu = 1'b0;
      w_grant_dev = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            // On a tie the master that did not win last time gets the bus.
            if (w_cpu_req && (!dev_req || (r_last_grant == GRANT_DEV))) begin
               w_grant_cpu = 1'b1;
               w_next      = ST_CPU_ACC;
            end else if (dev_req) begin
               w_grant_dev = 1'b1;
               w_next      = ST_DEV_ACC;
            end
         end
         ST_CPU_ACC:  if (w_zero) w_next = ST_CPU_DONE;
         ST_DEV_ACC:  if (w_zero) w_next = ST_DEV_DONE;
         ST_CPU_DONE: w_next = ST_IDLE;
         ST_DEV_DONE: w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   assign w_acc  = (r_state == ST_CPU_ACC)  || (r_state == ST_DEV_ACC);
   assign w_done = (r_state == ST_CPU_DONE) || (r_state == ST_DEV_DONE);

   assign mem_a     = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_n_oe  = ~(w_acc & ~r_we);
   assign mem_n_we  = ~(w_acc & r_we);
   assign mem_d_oe  = (w_acc | w_done) & r_we;

   assign cpu_rdata = r_cpu_rdata;
   assign dev_rdata = r_dev_rdata;
   assign dev_ack   = (r_state == ST_DEV_DONE);
   assign cpu_n_rdy = w_cpu_req & (r_state != ST_CPU_DONE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (ACCESS_CYCLES=2) against a small RAM model
// that commits on the rising edge of mem_n_we while data is still driven.
module tb_mem_bus_arbiter;

   logic        clk_in;
   logic        n_rst;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_wdata;
   logic        cpu_n_oe;
   logic        cpu_n_we;
   logic [7:0]  cpu_rdata;
   logic        cpu_n_rdy;
   logic        dev_req;
   logic        dev_we;
   logic [15:0] dev_a;
   logic [7:0]  dev_wdata;
   logic        dev_ack;
   logic [7:0]  dev_rdata;
   logic [15:0] mem_a;
   logic [7:0]  mem_wdata;
   logic        mem_d_oe;
   logic [7:0]  mem_rdata;
   logic        mem_n_oe;
   logic        mem_n_we;

   logic [7:0]  ram [0:65535];
   logic        prev_n_we;
   int          n_checks;
   int          n_errors;
   int          stall;

   mem_bus_arbiter #(.ACCESS_CYCLES(2), .ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
      .clk_in    (clk_in),
      .n_rst     (n_rst),
      .cpu_a     (cpu_a),
      .cpu_wdata (cpu_wdata),
      .cpu_n_oe  (cpu_n_oe),
      .cpu_n_we  (cpu_n_we),
      .cpu_rdata (cpu_rdata),
      .cpu_n_rdy (cpu_n_rdy),
      .dev_req   (dev_req),
      .dev_we    (dev_we),
      .dev_a     (dev_a),
      .dev_wdata (dev_wdata),
      .dev_ack   (dev_ack),
      .dev_rdata (dev_rdata),
      .mem_a     (mem_a),
      .mem_wdata (mem_wdata),
      .mem_d_oe  (mem_d_oe),
      .mem_rdata (mem_rdata),
      .mem_n_oe  (mem_n_oe),
      .mem_n_we  (mem_n_we)
   );

   assign mem_rdata = ram[mem_a];

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge; the RAM commits when the write strobe has
   // just risen while the arbiter still drives the data bus.
   task automatic step();
      @(negedge clk_in);
      if (!prev_n_we && mem_n_we && mem_d_oe) ram[mem_a] = mem_wdata;
      prev_n_we = mem_n_we;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      prev_n_we = 1'b1;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      ram[16'h0100] = 8'h55;
      ram[16'h0101] = 8'h77;
      ram[16'h0200] = 8'hA5;
      ram[16'h0300] = 8'h5A;
      ram[16'h0400] = 8'h96;
      n_rst     = 1'b0;
      cpu_a     = '0;
      cpu_wdata = '0;
      cpu_n_oe  = 1'b1;
      cpu_n_we  = 1'b1;
      dev_req   = 1'b0;
      dev_we    = 1'b0;
      dev_a     = '0;
      dev_wdata = '0;

      // Reset state
      step();
      step();
      check("rst_n_oe", mem_n_oe, 1);
      check("rst_n_we", mem_n_we, 1);
      check("rst_d_oe", mem_d_oe, 0);
      check("rst_ack", dev_ack, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_dev_rdata", dev_rdata, 0);
      check("rst_n_rdy", cpu_n_rdy, 0);
      n_rst = 1'b1;

      // 1: reset during a device write aborts it
      step();
      dev_req = 1'b1; dev_we = 1'b1; dev_a = 16'h0100; dev_wdata = 8'hEE;
      step();
      check("t1_n_we_low", mem_n_we, 0);
      check("t1_d_oe", mem_d_oe, 1);
      n_rst = 1'b0;
      step();
      check("t1_n_we_abort", mem_n_we, 1);
      check("t1_d_oe_abort", mem_d_oe, 0);
      check("t1_ack_abort", dev_ack, 0);
      n_rst = 1'b1; dev_req = 1'b0;
      step();
      check("t1_ack_after", dev_ack, 0);
      check("t1_n_we_idle", mem_n_we, 1);
      check("t1_ram", ram[16'h0100], 8'h55);

      // 2: lone CPU read
      cpu_n_oe = 1'b0; cpu_a = 16'h0200;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("t2_n_oe", mem_n_oe, (k == 1 || k == 2) ? 0 : 1);
         check("t2_n_we", mem_n_we, 1);
         if (k <= 3) check("t2_n_rdy", cpu_n_rdy, (k == 3) ? 0 : 1);
         if (k <= 2) check("t2_mem_a", mem_a, 16'h0200);
         if (k == 3) begin
            check("t2_rdata", cpu_rdata, 8'hA5);
            cpu_n_oe = 1'b1;
         end
      end

      // 3: lone device write
      dev_req = 1'b1; dev_we = 1'b1; dev_a = 16'h1000; dev_wdata = 8'h3C;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("t3_n_we", mem_n_we, (k <= 2) ? 0 : 1);
         check("t3_d_oe", mem_d_oe, (k <= 3) ? 1 : 0);
         check("t3_ack", dev_ack, (k == 3) ? 1 : 0);
         if (k <= 3) begin
            check("t3_mem_a", mem_a, 16'h1000);
            check("t3_wdata", mem_wdata, 8'h3C);
         end
         if (k == 3) dev_req = 1'b0;
      end
      check("t3_ram", ram[16'h1000], 8'h3C);

      // 4: tie after reset, CPU first, then strict alternation
      n_rst = 1'b0;
      step();
      n_rst = 1'b1;
      step();
      cpu_n_we = 1'b0; cpu_a = 16'h0100; cpu_wdata = 8'h11;
      dev_req = 1'b1; dev_we = 1'b0; dev_a = 16'h0101;
      for (int k = 1; k <= 48; k++) begin
         step();
         check("t4_n_rdy", cpu_n_rdy, (k % 8 == 3) ? 0 : 1);
         check("t4_ack", dev_ack, (k % 8 == 7) ? 1 : 0);
         if (k == 1) begin
            check("t4_cpu_first_we", mem_n_we, 0);
            check("t4_cpu_first_a", mem_a, 16'h0100);
         end
         if (k == 4) check("t4_ram", ram[16'h0100], 8'h11);
         if (k == 7) check("t4_dev_rdata", dev_rdata, 8'h77);
      end
      cpu_n_we = 1'b1; dev_req = 1'b0;

      // 5: CPU arrives while the device owns the bus
      step();
      dev_req = 1'b1; dev_we = 1'b0; dev_a = 16'h0101;
      step();
      check("t5_dev_owns", mem_n_oe, 0);
      cpu_n_oe = 1'b0; cpu_a = 16'h0400;
      stall = 0;
      for (int k = 2; k <= 7; k++) begin
         step();
         if (cpu_n_rdy) stall++;
         check("t5_n_rdy", cpu_n_rdy, (k == 7) ? 0 : 1);
         check("t5_ack", dev_ack, (k == 3) ? 1 : 0);
         if (k == 3) dev_req = 1'b0;
         if (k == 7) begin
            check("t5_rdata", cpu_rdata, 8'h96);
            cpu_n_oe = 1'b1;
         end
      end
      check("t5_stall", stall, 5);

      // 6: CPU inputs are snapshotted at grant
      step();
      cpu_n_oe = 1'b0; cpu_a = 16'h0200;
      step();
      check("t6_mem_a1", mem_a, 16'h0200);
      cpu_a = 16'h0300;
      step();
      check("t6_mem_a2", mem_a, 16'h0200);
      check("t6_n_oe", mem_n_oe, 0);
      step();
      check("t6_mem_a3", mem_a, 16'h0200);
      check("t6_n_rdy", cpu_n_rdy, 0);
      check("t6_rdata", cpu_rdata, 8'hA5);
      cpu_n_oe = 1'b1;
      step();
      check("t6_idle_a", mem_a, 16'h0200);
      check("t6_idle_n_oe", mem_n_oe, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Owns the single 64K x 8 RAM bus and shares it between the CPU and one secondary bus master (DMA/loader/video fetch).
- Times the RAM control strobes itself and stalls the CPU through the CPU's n_rdy input.
- Sits between the cpu module's a/d/n_oe/n_we pins and the RAM.
- The device side uses a req/ack handshake.

Parameters:
- ACCESS_CYCLES, 2: cycles a strobe (mem_n_oe or mem_n_we) is held low per access; legal range 1..15.
- ADDR_WIDTH, 16: address width.
- DATA_WIDTH, 8: data width.

Ports:
- clk_in  in  1  system clock; all state changes on the rising edge.
- n_rst  in  1  synchronous active-low reset.
- cpu_a  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_n_oe  in  1  CPU read request, active low.
- cpu_n_we  in  1  CPU write request, active low.
- cpu_rdata  out  DATA_WIDTH  registered read data returned to the CPU.
- cpu_n_rdy  out  1  CPU ready, active low; 1 = stall.
- dev_req  in  1  device transfer request.
- dev_we  in  1  device direction: 1 = write, 0 = read.
- dev_a  in  ADDR_WIDTH  device address.
- dev_wdata  in  DATA_WIDTH  device write data.
- dev_ack  out  1  one-cycle transfer-complete pulse.
- dev_rdata  out  DATA_WIDTH  registered device read data.
- mem_a  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_d_oe  out  1  drive enable for mem_wdata onto the RAM data bus.
- mem_rdata  in  DATA_WIDTH  RAM read data.
- mem_n_oe  out  1  RAM output enable, active low.
- mem_n_we  out  1  RAM write strobe, active low; RAM commits on the rising edge.

Behaviour:
- Clock and reset:
  - Single clock clk_in; reset n_rst is synchronous, active-low.
  - While n_rst = 0 at an edge: state = IDLE; mem_n_oe = mem_n_we = 1; mem_d_oe = 0; dev_ack = 0; cpu_rdata = dev_rdata = 0; last_grant = DEV, so the CPU wins the first tie; counter = 0.
  - Reset asserted mid-access aborts it: strobes go high at that edge, no ack is issued, no n_rdy release.
- CPU request: cpu_req = ~cpu_n_oe | ~cpu_n_we. If both are low, this is a write.
- States: IDLE, CPU_ACC, CPU_DONE, DEV_ACC, DEV_DONE.
- IDLE:
  - Grant decision at each edge.
  - Only cpu_req -> CPU_ACC.
  - Only dev_req -> DEV_ACC.
  - Both -> grant the master not equal to last_grant.
  - On grant: latch address, data and direction into internal registers; load counter = ACCESS_CYCLES-1; set last_grant.
- CPU_ACC / DEV_ACC:
  - mem_a and mem_wdata come from the latched registers.
  - Read: mem_n_oe = 0.
  - Write: mem_n_we = 0 and mem_d_oe = 1.
  - Counter decrements each cycle; when it reaches 0 -> *_DONE.
  - Read data is captured into cpu_rdata / dev_rdata at that transition edge.
- CPU_DONE / DEV_DONE:
  - Strobes high; for writes, mem_a/mem_wdata/mem_d_oe are held, giving a one-cycle hold after the mem_n_we rising edge.
  - Always -> IDLE next edge.
- cpu_n_rdy (combinational):
  - 0 when state = CPU_DONE;
  - 0 when cpu_req = 0;
  - otherwise 1, including while the device owns the bus.
- dev_ack = 1 only in DEV_DONE.
- Device handshake:
  - The device must hold dev_req, dev_we, dev_a and dev_wdata stable until dev_ack.
  - A dev_req still high after ack is a new transfer.
  - dev_rdata holds until the next device read completes.
- Latency: an uncontended access takes ACCESS_CYCLES+2 cycles from the request-seen edge to the next IDLE; the CPU stalls ACCESS_CYCLES+1 cycles.
- Wait bound: with both masters continuously requesting, accesses strictly alternate; worst-case wait for either master = one foreign access (ACCESS_CYCLES+2 cycles).
- Snapshot rule: the CPU's inputs are sampled only at grant; changes during CPU_ACC are ignored.
- Back-to-back CPU: a CPU still requesting in the IDLE after CPU_DONE starts a fresh access, treated as the next bus cycle.
- mem_a in IDLE holds the last latched address, with no strobes asserted.

Decomposition:
- Shared include mem_arb_defs.vh:
  - state encodings (IDLE=0, CPU_ACC=1, CPU_DONE=2, DEV_ACC=3, DEV_DONE=4);
  - grant encodings (GRANT_CPU=0, GRANT_DEV=1);
  - 4-bit counter width.
- One sub-module, access_timer:
  - loadable down-counter with load/enable inputs and a zero flag;
  - reused when more masters are added.
- Grant logic and FSM stay in mem_bus_arbiter.

Test Plan (ACCESS_CYCLES=2, 1-port-per-address RAM model committing on mem_n_we rising edge):
1. Reset mid-write: assert n_rst=0 during DEV_ACC write to 0x0100 -> mem_n_we=1 at next edge, ram[0x0100] unchanged, dev_ack never pulses, state IDLE.
2. CPU read alone: ram[0x0200]=0xA5; cpu_n_oe=0, cpu_a=0x0200 -> mem_n_oe low exactly 2 cycles; cpu_n_rdy=1 for 2 cycles then 0 for 1 cycle; cpu_rdata=0xA5.
3. Device write alone: dev_req=1, dev_we=1, dev_a=0x1000, dev_wdata=0x3C -> mem_n_we low 2 cycles; mem_d_oe high 3 cycles; dev_ack one cycle after the strobe rises; ram[0x1000]=0x3C.
4. Simultaneous first requests after reset: CPU write 0x0100<=0x11 and device read 0x0101 -> CPU served first; device ack arrives 4 cycles later; then strict alternation over 6 continuous requests each (C,D,C,D,...).
5. Device holds bus, CPU arrives during DEV_ACC -> cpu_n_rdy stays 1 through DEV_DONE and CPU_ACC; released exactly in CPU_DONE; total CPU stall 5 cycles.
6. Snapshot check: change cpu_a from 0x0200 to 0x0300 during CPU_ACC -> mem_a stays 0x0200 for the whole access; returned data is from 0x0200.
